// File: rtl/fu_branch_q_if.sv
// rtl/fu_branch_q_if.sv - issue, flush and result bundle of the branch execution unit
interface fu_branch_q_if #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7
);
    logic              issue_valid;
    logic              issue_ready;
    logic [6:0]        issue_opcode;
    logic [2:0]        issue_func3;
    logic [XLEN-1:0]   issue_pc;
    logic [XLEN-1:0]   issue_imm;
    logic [PREG_W-1:0] issue_pd;
    logic [TAG_W-1:0]  issue_rob_tag;
    logic              issue_pred_taken;
    logic [XLEN-1:0]   issue_pred_target;
    logic [XLEN-1:0]   ps1_data;
    logic [XLEN-1:0]   ps2_data;

    logic              flush_valid;
    logic [TAG_W-1:0]  flush_tag;
    logic [TAG_W-1:0]  rob_tail;

    logic              out_valid;
    logic              out_ready;
    logic [TAG_W-1:0]  out_rob_tag;
    logic [PREG_W-1:0] out_pd;
    logic              out_wr_en;
    logic [XLEN-1:0]   out_data;
    logic              out_redirect;
    logic [XLEN-1:0]   out_redirect_pc;
    logic              out_illegal;

    modport master (
        output issue_valid, issue_opcode, issue_func3, issue_pc, issue_imm, issue_pd,
               issue_rob_tag, issue_pred_taken, issue_pred_target, ps1_data, ps2_data,
               flush_valid, flush_tag, rob_tail, out_ready,
        input  issue_ready, out_valid, out_rob_tag, out_pd, out_wr_en, out_data,
               out_redirect, out_redirect_pc, out_illegal
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_func3, issue_pc, issue_imm, issue_pd,
               issue_rob_tag, issue_pred_taken, issue_pred_target, ps1_data, ps2_data,
               flush_valid, flush_tag, rob_tail, out_ready,
        output issue_ready, out_valid, out_rob_tag, out_pd, out_wr_en, out_data,
               out_redirect, out_redirect_pc, out_illegal
    );
endinterface

// File: rtl/fu_branch_q.sv
// rtl/fu_branch_q.sv - branch/jump resolve unit with flushable result queue
module fu_branch_q #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 5,
    parameter int PREG_W = 7,
    parameter int DEPTH  = 4
) (
    input  logic          clk,
    input  logic          reset,
    fu_branch_q_if.slave  bq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Queue storage, one slot per result
    logic [DEPTH-1:0]  q_valid;
    logic [TAG_W-1:0]  q_tag         [DEPTH];
    logic [PREG_W-1:0] q_pd          [DEPTH];
    logic [DEPTH-1:0]  q_wr_en;
    logic [XLEN-1:0]   q_data        [DEPTH];
    logic [DEPTH-1:0]  q_redirect;
    logic [XLEN-1:0]   q_redirect_pc [DEPTH];
    logic [DEPTH-1:0]  q_illegal;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    // Resolve results for the instruction currently presented
    logic              is_b;
    logic              is_jal;
    logic              is_jalr;
    logic              taken;
    logic              illegal;
    logic              redirect;
    logic              wr_en;
    logic [XLEN-1:0]   pc4;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   redirect_pc;
    logic [XLEN-1:0]   link;

    logic              accept;
    logic              kill_issue;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  kill_mask;

    // Tag t is younger than the flushing instruction when it lies strictly
    // between flush_tag and rob_tail on the circular ROB index space.
    function automatic logic in_window(input logic [TAG_W-1:0] t,
                                       input logic [TAG_W-1:0] ftag,
                                       input logic [TAG_W-1:0] rtail);
        logic [TAG_W-1:0] d;
        logic [TAG_W-1:0] w;
        d = t - ftag;
        w = rtail - ftag;
        return (d != '0) && (d < w);
    endfunction

    // Evaluate condition, target, misprediction and link value
    always_comb begin
        is_b     = (bq.issue_opcode == OP_BRANCH);
        is_jal   = (bq.issue_opcode == OP_JAL);
        is_jalr  = (bq.issue_opcode == OP_JALR);
        pc4      = bq.issue_pc + XLEN'(4);
        jalr_sum = bq.ps1_data + bq.issue_imm;
        target   = bq.issue_pc + bq.issue_imm;
        taken    = 1'b0;
        illegal  = 1'b0;
        if (is_jal) begin
            taken = 1'b1;
        end else if (is_jalr) begin
            taken  = 1'b1;
            target = jalr_sum & ~XLEN'(1);
        end else if (is_b) begin
            case (bq.issue_func3)
                3'b000:  taken = (bq.ps1_data == bq.ps2_data);
                3'b001:  taken = (bq.ps1_data != bq.ps2_data);
                3'b100:  taken = ($signed(bq.ps1_data) <  $signed(bq.ps2_data));
                3'b101:  taken = ($signed(bq.ps1_data) >= $signed(bq.ps2_data));
                3'b110:  taken = (bq.ps1_data <  bq.ps2_data);
                3'b111:  taken = (bq.ps1_data >= bq.ps2_data);
                default: illegal = 1'b1;
            endcase
        end
        redirect    = (taken != bq.issue_pred_taken) ||
                      (taken && (target != bq.issue_pred_target));
        redirect_pc = taken ? target : pc4;
        wr_en       = (is_jal || is_jalr) && (bq.issue_pd != '0);
        link        = (is_jal || is_jalr) ? pc4 : '0;
    end

    // Handshake, flush kill decisions and queue movement
    always_comb begin
        accept     = bq.issue_valid && bq.issue_ready;
        kill_issue = bq.flush_valid && in_window(bq.issue_rob_tag, bq.flush_tag, bq.rob_tail);
        push       = accept && !kill_issue;
        pop        = (count != '0) && (!q_valid[head] || bq.out_ready);
        kill_mask  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_mask[i] = bq.flush_valid && in_window(q_tag[i], bq.flush_tag, bq.rob_tail);
        end
    end

    // Queue state: kill younger entries, write tail on push, advance on pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            q_valid    <= '0;
            q_wr_en    <= '0;
            q_redirect <= '0;
            q_illegal  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_tag[i]         <= '0;
                q_pd[i]          <= '0;
                q_data[i]        <= '0;
                q_redirect_pc[i] <= '0;
            end
        end else begin
            q_valid <= q_valid & ~kill_mask;
            if (push) begin
                q_valid[tail]       <= 1'b1;
                q_tag[tail]         <= bq.issue_rob_tag;
                q_pd[tail]          <= bq.issue_pd;
                q_wr_en[tail]       <= wr_en;
                q_data[tail]        <= link;
                q_redirect[tail]    <= redirect;
                q_redirect_pc[tail] <= redirect_pc;
                q_illegal[tail]     <= illegal;
                tail                <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign bq.issue_ready     = (count < CNT_W'(DEPTH));
    assign bq.out_valid       = (count != '0) && q_valid[head];
    assign bq.out_rob_tag     = q_tag[head];
    assign bq.out_pd          = q_pd[head];
    assign bq.out_wr_en       = bq.out_valid && q_wr_en[head];
    assign bq.out_data        = q_data[head];
    assign bq.out_redirect    = bq.out_valid && q_redirect[head];
    assign bq.out_redirect_pc = q_redirect_pc[head];
    assign bq.out_illegal     = bq.out_valid && q_illegal[head];
endmodule

// File: tb/tb_fu_branch_q.sv
// tb/tb_fu_branch_q.sv - directed bench for fu_branch_q
module tb_fu_branch_q;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 5;
    localparam int PREG_W = 7;
    localparam int DEPTH  = 4;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fu_branch_q_if #(.XLEN(XLEN), .TAG_W(TAG_W), .PREG_W(PREG_W)) bq ();

    fu_branch_q #(.XLEN(XLEN), .TAG_W(TAG_W), .PREG_W(PREG_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bq    (bq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [6:0] pd, input logic [4:0] tag,
                       input logic pt, input logic [31:0] ptgt);
        bq.issue_opcode      = op;
        bq.issue_func3       = f3;
        bq.issue_pc          = pc;
        bq.issue_imm         = imm;
        bq.ps1_data          = s1;
        bq.ps2_data          = s2;
        bq.issue_pd          = pd;
        bq.issue_rob_tag     = tag;
        bq.issue_pred_taken  = pt;
        bq.issue_pred_target = ptgt;
        bq.issue_valid       = 1'b1;
    endtask

    task automatic put_nt(input logic [4:0] tag);
        put(OP_B, 3'b000, 32'h100, 32'h10, 32'd1, 32'd2, 7'd0, tag, 1'b0, 32'h0);
    endtask

    task automatic issue_one();
        tick();
        bq.issue_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bq.issue_valid = 1'b0;
        put_nt(5'd0);
        bq.issue_valid = 1'b0;
        bq.flush_valid = 1'b0;
        bq.flush_tag   = '0;
        bq.rob_tail    = '0;
        bq.out_ready   = 1'b0;
        tick();
        tick();

        chk("rst_issue_ready", bq.issue_ready, 1);
        chk("rst_out_valid", bq.out_valid, 0);
        chk("rst_wr_en", bq.out_wr_en, 0);
        chk("rst_redirect", bq.out_redirect, 0);
        chk("rst_illegal", bq.out_illegal, 0);
        chk("rst_data", bq.out_data, 0);
        chk("rst_redirect_pc", bq.out_redirect_pc, 0);
        chk("rst_tag", bq.out_rob_tag, 0);
        chk("rst_pd", bq.out_pd, 0);
        reset = 1'b1;
        bq.out_ready = 1'b1;

        put(OP_JALR, 3'b000, 32'd1000, 32'd21, 32'd500, 32'd0, 7'd5, 5'd1, 1'b1, 32'd520);
        issue_one();
        chk("jalr_valid", bq.out_valid, 1);
        chk("jalr_tag", bq.out_rob_tag, 1);
        chk("jalr_pd", bq.out_pd, 5);
        chk("jalr_data", bq.out_data, 1004);
        chk("jalr_wr_en", bq.out_wr_en, 1);
        chk("jalr_redirect", bq.out_redirect, 0);
        chk("jalr_rpc", bq.out_redirect_pc, 520);

        put(OP_JALR, 3'b000, 32'd1000, 32'd21, 32'd500, 32'd0, 7'd5, 5'd2, 1'b1, 32'd600);
        issue_one();
        chk("jalr2_tag", bq.out_rob_tag, 2);
        chk("jalr2_redirect", bq.out_redirect, 1);
        chk("jalr2_rpc", bq.out_redirect_pc, 520);

        put(OP_B, 3'b001, 32'd2000, 32'd100, 32'd10, 32'd20, 7'd0, 5'd3, 1'b0, 32'd0);
        issue_one();
        chk("bne_redirect", bq.out_redirect, 1);
        chk("bne_rpc", bq.out_redirect_pc, 2100);
        chk("bne_wr_en", bq.out_wr_en, 0);
        chk("bne_data", bq.out_data, 0);

        put(OP_B, 3'b000, 32'd3000, 32'd8, 32'd50, 32'd50, 7'd0, 5'd4, 1'b0, 32'd0);
        issue_one();
        chk("beq_np_redirect", bq.out_redirect, 1);
        chk("beq_np_rpc", bq.out_redirect_pc, 3008);

        put(OP_B, 3'b000, 32'd3000, 32'd8, 32'd50, 32'd50, 7'd0, 5'd5, 1'b1, 32'd3008);
        issue_one();
        chk("beq_p_redirect", bq.out_redirect, 0);

        put(OP_B, 3'b100, 32'd4000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 7'd0, 5'd6, 1'b0, 32'd0);
        issue_one();
        chk("blt_redirect", bq.out_redirect, 1);
        chk("blt_rpc", bq.out_redirect_pc, 3984);

        put(OP_B, 3'b110, 32'd4000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 7'd0, 5'd7, 1'b0, 32'd0);
        issue_one();
        chk("bltu_redirect", bq.out_redirect, 0);
        chk("bltu_rpc", bq.out_redirect_pc, 4004);
        chk("bltu_illegal", bq.out_illegal, 0);

        put(OP_B, 3'b010, 32'd4000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 7'd0, 5'd8, 1'b0, 32'd0);
        issue_one();
        chk("ill_illegal", bq.out_illegal, 1);
        chk("ill_redirect", bq.out_redirect, 0);
        chk("ill_rpc", bq.out_redirect_pc, 4004);

        put(OP_JAL, 3'b000, 32'h100, 32'h40, 32'd0, 32'd0, 7'd0, 5'd9, 1'b1, 32'h140);
        issue_one();
        chk("jal_wr_en", bq.out_wr_en, 0);
        chk("jal_data", bq.out_data, 32'h104);
        chk("jal_redirect", bq.out_redirect, 0);
        tick();
        chk("drain_empty", bq.out_valid, 0);

        bq.out_ready = 1'b0;
        put_nt(5'd10); issue_one();
        put_nt(5'd11); issue_one();
        put_nt(5'd12); issue_one();
        chk("bp_ready3", bq.issue_ready, 1);
        put_nt(5'd13); issue_one();
        chk("bp_full_ready", bq.issue_ready, 0);
        put_nt(5'd14);
        tick();
        chk("bp_held_ready", bq.issue_ready, 0);
        chk("bp_held_tag", bq.out_rob_tag, 10);
        bq.out_ready = 1'b1;
        tick();
        chk("bp_drain_11", bq.out_rob_tag, 11);
        chk("bp_ready_after_pop", bq.issue_ready, 1);
        tick();
        bq.issue_valid = 1'b0;
        chk("bp_drain_12", bq.out_rob_tag, 12);
        tick();
        chk("bp_drain_13", bq.out_rob_tag, 13);
        tick();
        chk("bp_drain_14", bq.out_rob_tag, 14);
        chk("bp_drain_14_valid", bq.out_valid, 1);
        tick();
        chk("bp_empty", bq.out_valid, 0);

        bq.out_ready = 1'b0;
        put_nt(5'd29); issue_one();
        put_nt(5'd31); issue_one();
        put_nt(5'd0);  issue_one();
        put_nt(5'd5);  issue_one();
        chk("wrap_full", bq.issue_ready, 0);
        bq.flush_valid = 1'b1;
        bq.flush_tag   = 5'd30;
        bq.rob_tail    = 5'd2;
        put_nt(5'd1);
        tick();
        bq.flush_valid = 1'b0;
        bq.issue_valid = 1'b0;
        chk("wrap_head_valid", bq.out_valid, 1);
        chk("wrap_head_29", bq.out_rob_tag, 29);
        bq.out_ready = 1'b1;
        tick();
        chk("wrap_dead31", bq.out_valid, 0);
        tick();
        chk("wrap_dead0", bq.out_valid, 0);
        tick();
        chk("wrap_valid5", bq.out_valid, 1);
        chk("wrap_tag5", bq.out_rob_tag, 5);
        tick();
        chk("wrap_empty", bq.out_valid, 0);
        chk("wrap_ready", bq.issue_ready, 1);

        bq.out_ready = 1'b0;
        put_nt(5'd10); issue_one();
        bq.flush_valid = 1'b1;
        bq.flush_tag   = 5'd10;
        bq.rob_tail    = 5'd14;
        put_nt(5'd12);
        chk("kill_issue_ready", bq.issue_ready, 1);
        tick();
        bq.flush_valid = 1'b0;
        bq.issue_valid = 1'b0;
        chk("kill_flush_tag_kept", bq.out_valid, 1);
        chk("kill_flush_tag_val", bq.out_rob_tag, 10);
        bq.out_ready = 1'b1;
        tick();
        chk("kill_issue_dropped", bq.out_valid, 0);

        bq.out_ready = 1'b0;
        put_nt(5'd7); issue_one();
        bq.flush_valid = 1'b1;
        bq.flush_tag   = 5'd6;
        bq.rob_tail    = 5'd7;
        tick();
        chk("empty_win_valid", bq.out_valid, 1);
        chk("empty_win_tag", bq.out_rob_tag, 7);
        bq.rob_tail  = 5'd9;
        bq.out_ready = 1'b1;
        tick();
        bq.flush_valid = 1'b0;
        chk("flush_pop_empty", bq.out_valid, 0);
        put_nt(5'd3); issue_one();
        chk("flush_pop_next_valid", bq.out_valid, 1);
        chk("flush_pop_next_tag", bq.out_rob_tag, 3);
        tick();
        chk("flush_pop_drained", bq.out_valid, 0);

        bq.out_ready = 1'b0;
        put_nt(5'd20); issue_one();
        put_nt(5'd21); issue_one();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_rst_valid", bq.out_valid, 0);
        chk("mid_rst_ready", bq.issue_ready, 1);
        chk("mid_rst_tag", bq.out_rob_tag, 0);
        bq.out_ready = 1'b1;
        tick();
        chk("mid_rst_still_empty", bq.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
